// File: rtl/fib_pkg.sv
// fib_pkg: shared widths, limits, FSM states and term arithmetic for the Fibonacci checker
package fib_pkg;
   localparam int TERM_W = 8;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
   typedef enum logic [1:0] {EMPTY, ONE, TRACK, FAULT} state_t;
   function automatic logic [TERM_W-1:0] fib_add(input logic [TERM_W-1:0] a, input logic [TERM_W-1:0] b);
      return a + b;
   endfunction
endpackage

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: verifies an 8-bit modulo-256 Fibonacci stream and tracks lock/error status
module fibonacci_checker
   import fib_pkg::*;
(
   input  logic              clk,
   input  logic              restart_n,
   input  logic              in_valid,
   input  logic [TERM_W-1:0] in_data,
   input  logic              clr_err,
   output logic              locked,
   output logic              mismatch,
   output logic              resync,
   output logic              err_sticky,
   output logic [TERM_W-1:0] expected,
   output logic [CNT_W-1:0]  term_cnt
);
   state_t state, n_state;
   logic [TERM_W-1:0] f0, f1, n_f0, n_f1, n_expected;
   logic [CNT_W-1:0] n_cnt, cnt_inc;
   logic n_locked, n_mismatch, n_resync;
   assign cnt_inc = (term_cnt == CNT_MAX) ? term_cnt : term_cnt + 8'd1;
   // next-state and next-output decode for one accepted term; invalid cycles hold everything
   always_comb begin
      n_state = state;
      n_f0 = f0;
      n_f1 = f1;
      n_cnt = term_cnt;
      n_locked = locked;
      n_mismatch = 1'b0;
      n_resync = 1'b0;
      if (in_valid) begin
         case (state)
            EMPTY: if (in_data == '0) begin
               n_f1 = '0;
               n_cnt = 8'd1;
               n_state = ONE;
            end
            ONE: if (in_data == 8'd1) begin
               n_f0 = '0;
               n_f1 = 8'd1;
               n_cnt = 8'd2;
               n_state = TRACK;
            end else if (in_data == '0) begin
               n_f1 = '0;
               n_cnt = 8'd1;
               n_resync = 1'b1;
            end else begin
               n_mismatch = 1'b1;
               n_state = FAULT;
            end
            TRACK: if (in_data == expected) begin
               n_f0 = f1;
               n_f1 = in_data;
               n_cnt = cnt_inc;
               n_locked = 1'b1;
            end else if (in_data == '0) begin
               n_f1 = '0;
               n_cnt = 8'd1;
               n_resync = 1'b1;
               n_locked = 1'b0;
               n_state = ONE;
            end else begin
               n_mismatch = 1'b1;
               n_locked = 1'b0;
               n_state = FAULT;
            end
            FAULT: if (in_data == '0) begin
               n_f1 = '0;
               n_cnt = 8'd1;
               n_resync = 1'b1;
               n_state = ONE;
            end
            default: n_state = EMPTY;
         endcase
      end
   end
   assign n_expected = (n_state == TRACK) ? fib_add(n_f0, n_f1) : (n_state == ONE) ? 8'd1 : 8'd0;
   // register state, terms and all outputs; a new mismatch beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!restart_n) begin
         state <= EMPTY;
         f0 <= '0;
         f1 <= '0;
         term_cnt <= '0;
         locked <= 1'b0;
         mismatch <= 1'b0;
         resync <= 1'b0;
         err_sticky <= 1'b0;
         expected <= '0;
      end else begin
         state <= n_state;
         f0 <= n_f0;
         f1 <= n_f1;
         term_cnt <= n_cnt;
         locked <= n_locked;
         mismatch <= n_mismatch;
         resync <= n_resync;
         err_sticky <= n_mismatch | (err_sticky & ~clr_err);
         expected <= n_expected;
      end
   end
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: table vectors plus generator-driven sequences, scored through an expectation queue
module tb_fibonacci_checker;
   typedef struct packed {
      logic       locked;
      logic       mismatch;
      logic       resync;
      logic       err;
      logic [7:0] exp;
      logic [7:0] cnt;
   } out_t;
   typedef struct {
      logic rn;
      logic v;
      logic [7:0] d;
      logic ce;
      out_t o;
   } vec_t;
   logic clk = 1'b0;
   logic restart_n = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic clr_err = 1'b0;
   logic locked, mismatch, resync, err_sticky;
   logic [7:0] expected, term_cnt;
   int n_checks = 0;
   int n_pass = 0;
   out_t exp_q[$];
   vec_t tbl[$];
   fibonacci_checker dut (
      .clk(clk), .restart_n(restart_n), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
      .locked(locked), .mismatch(mismatch), .resync(resync), .err_sticky(err_sticky),
      .expected(expected), .term_cnt(term_cnt)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(input logic rn, input logic v, input logic [7:0] d, input logic ce,
                               input logic l, input logic m, input logic r, input logic e,
                               input logic [7:0] x, input logic [7:0] c);
      vec_t t;
      t.rn = rn; t.v = v; t.d = d; t.ce = ce;
      t.o = '{locked: l, mismatch: m, resync: r, err: e, exp: x, cnt: c};
      return t;
   endfunction
   task automatic compare(input string name, input int idx);
      out_t want, got;
      want = exp_q.pop_front();
      got = {locked, mismatch, resync, err_sticky, expected, term_cnt};
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s[%0d]: got lock=%b mis=%b res=%b err=%b exp=%0d cnt=%0d, want lock=%b mis=%b res=%b err=%b exp=%0d cnt=%0d",
                    name, idx, got.locked, got.mismatch, got.resync, got.err, got.exp, got.cnt,
                    want.locked, want.mismatch, want.resync, want.err, want.exp, want.cnt);
   endtask
   task automatic step(input string name, input int idx, input logic rn, input logic v, input logic [7:0] d,
                       input logic ce, input out_t o);
      restart_n = rn; in_valid = v; in_data = d; clr_err = ce;
      exp_q.push_back(o);
      @(posedge clk);
      #1;
      compare(name, idx);
   endtask
   task automatic fib_run(input string name, input int n);
      logic [7:0] a, b, t;
      a = 8'd0; b = 8'd1;
      for (int k = 0; k < n; k++) begin
         t = a; a = b; b = t + b;
         step(name, k, 1'b1, 1'b1, t, 1'b0,
              '{locked: (k >= 2), mismatch: 1'b0, resync: 1'b0, err: 1'b0, exp: a,
                cnt: (k + 1 > 255) ? 8'd255 : 8'(k + 1)});
      end
   endtask
   initial begin
      tbl.push_back(mk(0,0,8'd0,0,  0,0,0,0,8'd0,8'd0));
      tbl.push_back(mk(0,1,8'd0,1,  0,0,0,0,8'd0,8'd0));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,0,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd1,0,  0,0,0,0,8'd1,8'd2));
      tbl.push_back(mk(1,1,8'd1,0,  1,0,0,0,8'd2,8'd3));
      tbl.push_back(mk(1,1,8'd2,0,  1,0,0,0,8'd3,8'd4));
      tbl.push_back(mk(1,1,8'd3,0,  1,0,0,0,8'd5,8'd5));
      tbl.push_back(mk(1,1,8'd5,0,  1,0,0,0,8'd8,8'd6));
      tbl.push_back(mk(1,1,8'd8,0,  1,0,0,0,8'd13,8'd7));
      tbl.push_back(mk(1,1,8'd13,0, 1,0,0,0,8'd21,8'd8));
      tbl.push_back(mk(1,0,8'd99,0, 1,0,0,0,8'd21,8'd8));
      tbl.push_back(mk(0,1,8'd21,1, 0,0,0,0,8'd0,8'd0));
      tbl.push_back(mk(1,1,8'd5,0,  0,0,0,0,8'd0,8'd0));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,0,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd1,0,  0,0,0,0,8'd1,8'd2));
      tbl.push_back(mk(1,1,8'd1,0,  1,0,0,0,8'd2,8'd3));
      tbl.push_back(mk(1,1,8'd2,0,  1,0,0,0,8'd3,8'd4));
      tbl.push_back(mk(1,1,8'd3,0,  1,0,0,0,8'd5,8'd5));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,1,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,1,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd1,0,  0,0,0,0,8'd1,8'd2));
      tbl.push_back(mk(1,1,8'd1,0,  1,0,0,0,8'd2,8'd3));
      tbl.push_back(mk(1,0,8'd0,0,  1,0,0,0,8'd2,8'd3));
      tbl.push_back(mk(1,1,8'd2,0,  1,0,0,0,8'd3,8'd4));
      tbl.push_back(mk(1,1,8'd4,1,  0,1,0,1,8'd0,8'd4));
      tbl.push_back(mk(1,1,8'd7,0,  0,0,0,1,8'd0,8'd4));
      tbl.push_back(mk(1,0,8'd0,1,  0,0,0,0,8'd0,8'd4));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,1,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd1,0,  0,0,0,0,8'd1,8'd2));
      tbl.push_back(mk(1,1,8'd1,0,  1,0,0,0,8'd2,8'd3));
      tbl.push_back(mk(1,1,8'd2,0,  1,0,0,0,8'd3,8'd4));
      tbl.push_back(mk(1,1,8'd4,0,  0,1,0,1,8'd0,8'd4));
      tbl.push_back(mk(1,1,8'd7,0,  0,0,0,1,8'd0,8'd4));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,1,1,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd1,0,  0,0,0,1,8'd1,8'd2));
      tbl.push_back(mk(1,1,8'd1,0,  1,0,0,1,8'd2,8'd3));
      tbl.push_back(mk(0,1,8'd0,1,  0,0,0,0,8'd0,8'd0));
      tbl.push_back(mk(1,1,8'd0,0,  0,0,0,0,8'd1,8'd1));
      tbl.push_back(mk(1,1,8'd5,0,  0,1,0,1,8'd0,8'd1));
      tbl.push_back(mk(1,1,8'd3,0,  0,0,0,1,8'd0,8'd1));
      tbl.push_back(mk(1,0,8'd0,0,  0,0,0,1,8'd0,8'd1));
      tbl.push_back(mk(0,0,8'd0,0,  0,0,0,0,8'd0,8'd0));
      foreach (tbl[i]) step("vec", i, tbl[i].rn, tbl[i].v, tbl[i].d, tbl[i].ce, tbl[i].o);
      fib_run("wrap", 15);
      n_checks++;
      if (expected === 8'd98 && term_cnt === 8'd15) n_pass++;
      else $display("FAIL wrap_end: got exp=%0d cnt=%0d, want exp=98 cnt=15", expected, term_cnt);
      step("rst", 0, 1'b0, 1'b0, 8'd0, 1'b0, '0);
      fib_run("sat", 300);
      step("sat_idle", 0, 1'b1, 1'b0, 8'd0, 1'b1, {1'b1, 1'b0, 1'b0, 1'b0, expected, 8'd255});
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port restart_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data carries a sequence term this cycle.
REQ-004 SHALL have port in_data, input, 8 bits: unsigned term from an 8-bit Fibonacci source.
REQ-005 SHALL have port clr_err, input, 1 bit: clears err_sticky.
REQ-006 SHALL have port locked, output, 1 bit: high while in TRACK after at least one verified term.
REQ-007 SHALL have port mismatch, output, 1 bit: one-cycle pulse, the cycle after a failing term.
REQ-008 SHALL have port resync, output, 1 bit: one-cycle pulse, the cycle after a restart term (0) is accepted mid-stream.
REQ-009 SHALL have port err_sticky, output, 1 bit: set by any mismatch, held until cleared.
REQ-010 SHALL have port expected, output, 8 bits: next term the checker will accept.
REQ-011 SHALL have port term_cnt, output, 8 bits: terms accepted since the last start; saturates at 255.

Function
REQ-012 SHALL implement FSM states EMPTY, ONE, TRACK, FAULT; all outputs registered.
REQ-013 SHALL hold term registers f0 (older) and f1 (newer), 8 bits each; expected = (f0+f1) mod 256 in TRACK, 1 in ONE, 0 in EMPTY/FAULT.
REQ-014 SHALL ignore cycles with in_valid low: no state, count or output-pulse change.
REQ-015 EMPTY: valid 0 -> f1=0, term_cnt=1, go ONE; valid nonzero -> discarded, stay EMPTY, no mismatch.
REQ-016 ONE: valid 1 -> f0=0, f1=1, term_cnt=2, go TRACK; valid 0 -> stay ONE, term_cnt=1, resync pulse; other -> mismatch pulse, go FAULT.
REQ-017 TRACK: valid == expected -> f0=f1, f1=in_data, term_cnt+1 (saturating), locked=1.
REQ-018 TRACK: valid != expected and in_data==0 -> f1=0, term_cnt=1, go ONE, resync pulse, no mismatch, locked=0.
REQ-019 TRACK: valid != expected and in_data!=0 -> mismatch pulse, err_sticky=1, locked=0, go FAULT.
REQ-020 FAULT: valid 0 -> f1=0, term_cnt=1, go ONE, resync pulse; other values -> stay FAULT, no further mismatch pulses.
REQ-021 A term equal to expected SHALL always be a match, even when it is 0 (wrap-around zero).
REQ-022 Addition SHALL be 8-bit modulo-256; the carry SHALL be discarded.
REQ-023 Mismatch/resync SHALL be visible exactly one cycle after the in_valid sample; expected updates in that same cycle.
REQ-024 If clr_err and a new mismatch coincide, err_sticky SHALL end set (set wins).
REQ-025 term_cnt SHALL stick at 255; locked and checking SHALL continue unaffected.

Reset
REQ-026 While restart_n low at a clock edge: state=EMPTY, f0=f1=0, term_cnt=0, locked=0, mismatch=0, resync=0, err_sticky=0, expected=0.
REQ-027 Reset SHALL take priority over in_valid and clr_err, including mid-sequence; the first valid term after release is handled as in EMPTY.

Structure
REQ-028 A shared package fib_pkg SHALL hold TERM_W=8, CNT_MAX=255 and the FSM state enumeration, also used by the generator bench.
REQ-029 No sub-module SHALL be used; FSM, term registers and counter are in one module.

Verification
REQ-030 Reset, then feed 0,1,1,2,3,5,8,13 -> no mismatch, locked=1 from the cycle after the third term, term_cnt=8, expected=21.
REQ-031 Feed 0,1,...,144,233 then 121 -> 121 accepted (377 mod 256), no mismatch, expected=98.
REQ-032 Feed 0,1,1,2 then 4 -> mismatch pulse one cycle, err_sticky=1, locked=0; then 7 -> no pulse; then 0,1,1 -> resync pulse, locked=1, err_sticky still 1.
REQ-033 Feed 0,1,1,2,3 then 0,1,1 (generator restart) -> resync pulse, no mismatch, term_cnt=3 at the end.
REQ-034 Assert clr_err in the same cycle a mismatch is registered -> err_sticky=1; assert clr_err alone next cycle -> err_sticky=0.
REQ-035 Pull restart_n low mid-TRACK with in_valid high -> all outputs 0 next cycle; a nonzero first term after release is discarded.
